// File: rtl/systolic_pkg.sv
// systolic_pkg: feeder state encoding and packed-lane slice helper
package systolic_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, GAP, STREAM, FLUSH} state_t;
  function automatic int lane_msb(input int k, input int size, input int width);
    return (size - k) * width - 1;
  endfunction
endpackage

// File: rtl/systolic_feeder_skew_line.sv
// skew_line: depth-stage shift register carrying one lane's data and valid bit
module skew_line #(
  parameter int width = 8,
  parameter int depth = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [width-1:0] i_data,
  input  logic             i_valid,
  output logic [width-1:0] o_data,
  output logic             o_valid
);
  logic [width:0] r_pipe [depth];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < depth; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {i_valid, i_data};
      for (int i = 1; i < depth; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign {o_valid, o_data} = r_pipe[depth-1];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads array weights and feeds diagonally skewed input rows
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int data_size = 8,
  parameter int size      = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_w_valid,
  output logic                      o_w_ready,
  input  logic [data_size*size-1:0] i_w_row,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [data_size*size-1:0] i_in_row,
  input  logic                      i_in_last,
  output logic [data_size*size-1:0] o_w_stream,
  output logic                      o_set_w,
  output logic [data_size*size-1:0] o_data_stream,
  output logic [size-1:0]           o_lane_valid,
  output logic                      o_busy
);
  localparam int cw = $clog2(size + 1);
  state_t r_state, w_next;
  logic [cw-1:0] r_row, w_row_n, r_flush, w_flush_n;
  logic r_w_loaded, w_loaded_n, r_stall, w_stall_n;
  logic w_w_acc, w_take;
  assign w_w_acc = o_w_ready & i_w_valid;
  assign w_take  = o_in_ready & i_in_valid & ~w_w_acc;
  always_comb begin
    w_next     = r_state;
    w_row_n    = r_row;
    w_flush_n  = r_flush;
    w_loaded_n = r_w_loaded;
    w_stall_n  = r_stall;
    case (r_state)
      IDLE: begin
        if (w_w_acc) begin
          w_next     = (size == 1) ? GAP : LOAD_W;
          w_row_n    = cw'(1);
          w_loaded_n = 1'b0;
          w_stall_n  = 1'b0;
        end else if (w_take) begin
          w_next    = !i_in_last ? STREAM : (size == 1) ? IDLE : FLUSH;
          w_flush_n = '0;
        end
      end
      LOAD_W: begin
        if (w_w_acc) begin
          w_row_n = r_row + cw'(1);
          if (r_row == cw'(size - 1)) w_next = GAP;
        end else begin
          w_stall_n = 1'b1;
        end
      end
      GAP: begin
        w_next     = IDLE;
        w_loaded_n = !r_stall;
      end
      STREAM: begin
        if (w_take && i_in_last) begin
          w_next    = (size == 1) ? IDLE : FLUSH;
          w_flush_n = '0;
        end
      end
      FLUSH: begin
        w_flush_n = r_flush + cw'(1);
        if (r_flush == cw'(size - 2)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_flush    <= '0;
      r_w_loaded <= 1'b0;
      r_stall    <= 1'b0;
      o_w_ready  <= 1'b0;
      o_in_ready <= 1'b0;
      o_busy     <= 1'b0;
      o_set_w    <= 1'b0;
      o_w_stream <= '0;
    end else begin
      r_state    <= w_next;
      r_row      <= w_row_n;
      r_flush    <= w_flush_n;
      r_w_loaded <= w_loaded_n;
      r_stall    <= w_stall_n;
      o_w_ready  <= w_next == IDLE || w_next == LOAD_W;
      o_in_ready <= w_next == STREAM || (w_next == IDLE && w_loaded_n);
      o_busy     <= w_next != IDLE;
      o_set_w    <= w_w_acc;
      if (w_w_acc) o_w_stream <= i_w_row;
    end
  end
  for (genvar k = 0; k < size; k++) begin : g_lane
    skew_line #(.width(data_size), .depth(k + 1)) u_line (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_data  (w_take ? i_in_row[lane_msb(k, size, data_size) -: data_size] : '0),
      .i_valid (w_take),
      .o_data  (o_data_stream[lane_msb(k, size, data_size) -: data_size]),
      .o_valid (o_lane_valid[k])
    );
  end
endmodule
